// File: rtl/and_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : and_operand_loader
// Description : Deserialises a bit-serial operand frame (a, then b, MSB-first)
//               into a parallel operand pair with a valid/ready output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module and_operand_loader #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_start,
    output logic             sin_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             frame_err
);

    localparam int C_FRAME_BITS = 2 * WIDTH;
    localparam int C_CNT_W      = (C_FRAME_BITS > 1) ? $clog2(C_FRAME_BITS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(C_FRAME_BITS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [C_CNT_W-1:0]        r_cnt;
    logic [C_CNT_W-1:0]        w_cnt_next;
    logic [C_FRAME_BITS-1:0]   r_shift;
    logic [C_FRAME_BITS-1:0]   w_shift_next;
    logic [C_FRAME_BITS-1:0]   w_frame;
    logic [C_FRAME_BITS-1:0]   w_first_bit;
    logic [WIDTH-1:0]          w_a_next;
    logic [WIDTH-1:0]          w_b_next;
    logic                      w_op_valid_next;
    logic                      w_frame_err_next;
    logic                      w_accept;
    logic                      w_take;

    assign sin_ready   = (r_state != S_FULL);
    assign w_accept    = sin_valid && sin_ready;
    assign w_take      = op_valid && op_ready;
    assign w_frame     = {r_shift[C_FRAME_BITS-2:0], sin_data};
    assign w_first_bit = {{(C_FRAME_BITS-1){1'b0}}, sin_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            a         <= '0;
            b         <= '0;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            a         <= w_a_next;
            b         <= w_b_next;
            op_valid  <= w_op_valid_next;
            frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_shift_next     = r_shift;
        w_a_next         = a;
        w_b_next         = b;
        // A consumed pair empties the slot unless a new pair lands this edge.
        w_op_valid_next  = op_valid && !op_ready;
        w_frame_err_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (sin_start) begin
                        w_shift_next = w_first_bit;
                        w_cnt_next   = C_CNT_ONE;
                        w_state_next = S_LOAD;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (w_accept) begin
                    if (sin_start) begin
                        w_shift_next     = w_first_bit;
                        w_cnt_next       = C_CNT_ONE;
                        w_frame_err_next = 1'b1;
                    end else if (r_cnt == C_LAST_BIT) begin
                        w_cnt_next = '0;
                        if (!op_valid || op_ready) begin
                            w_a_next        = w_frame[C_FRAME_BITS-1:WIDTH];
                            w_b_next        = w_frame[WIDTH-1:0];
                            w_op_valid_next = 1'b1;
                            w_state_next    = S_IDLE;
                        end else begin
                            w_shift_next = w_frame;
                            w_state_next = S_FULL;
                        end
                    end else begin
                        w_shift_next = w_frame;
                        w_cnt_next   = r_cnt + C_CNT_ONE;
                    end
                end
            end

            S_FULL: begin
                // Held frame moves into the slot the moment the old pair is taken.
                if (w_take) begin
                    w_a_next        = r_shift[C_FRAME_BITS-1:WIDTH];
                    w_b_next        = r_shift[WIDTH-1:0];
                    w_op_valid_next = 1'b1;
                    w_state_next    = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
